// File: rtl/conv_pkg.sv
// Shared constants for the CONV layer-memory responder: widths, bank depths
// and the csel codes that name each layer bank.
package conv_pkg;

  localparam int DATA_W   = 20;
  localparam int ADDR_W   = 12;
  localparam int L0_DEPTH = 4096;
  localparam int L1_DEPTH = 1024;

  localparam int L1_AW = $clog2(L1_DEPTH);
  localparam int CNT0_W = $clog2(L0_DEPTH) + 1;
  localparam int CNT1_W = $clog2(L1_DEPTH) + 1;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;
  // Codes held back for later layers; currently treated as illegal.
  localparam logic [2:0] CSEL_L2 = 3'b101;
  localparam logic [2:0] CSEL_L3 = 3'b111;

  // L1 only decodes the low address bits; anything above must be zero.
  function automatic logic l1_addr_ok(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:L1_AW] == '0;
  endfunction

endpackage

// File: rtl/conv_sp_ram.sv
// Single-clock RAM with one write port and one registered read port.
// A read of the address being written in the same cycle returns the new data.
module conv_sp_ram #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 20,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/conv_layer_mem.sv
// Layer-memory responder for CONV: banks L0/L1 with registered reads,
// saturating write counters, full flags and a sticky illegal-access flag.
module conv_layer_mem
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        csel,
  input  logic              cwr,
  input  logic [ADDR_W-1:0] caddr_wr,
  input  logic [DATA_W-1:0] cdata_wr,
  input  logic              crd,
  input  logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_rd,
  output logic [12:0]       wr_cnt0,
  output logic [10:0]       wr_cnt1,
  output logic              l0_full,
  output logic              l1_full,
  output logic              sel_err
);

  logic sel_l0, sel_l1;
  logic wr0, wr1, rd0, rd1, wr_bad, rd_bad;
  logic [DATA_W-1:0] rdata0, rdata1;

  logic              rd_valid_q, rd_valid_d;
  logic              rd_bank_q, rd_bank_d;
  logic [CNT0_W-1:0] cnt0_q, cnt0_d;
  logic [CNT1_W-1:0] cnt1_q, cnt1_d;
  logic              err_q, err_d;

  assign sel_l0 = (csel == CSEL_L0);
  assign sel_l1 = (csel == CSEL_L1);

  assign wr0    = cwr & sel_l0;
  assign wr1    = cwr & sel_l1 & l1_addr_ok(caddr_wr);
  assign rd0    = crd & sel_l0;
  assign rd1    = crd & sel_l1 & l1_addr_ok(caddr_rd);
  assign wr_bad = cwr & ~(wr0 | wr1);
  assign rd_bad = crd & ~(rd0 | rd1);

  conv_sp_ram #(.DEPTH(L0_DEPTH), .DATA_W(DATA_W)) u_l0 (
    .clk   (clk),
    .we    (wr0),
    .waddr (caddr_wr),
    .wdata (cdata_wr),
    .re    (rd0),
    .raddr (caddr_rd),
    .rdata (rdata0)
  );

  conv_sp_ram #(.DEPTH(L1_DEPTH), .DATA_W(DATA_W)) u_l1 (
    .clk   (clk),
    .we    (wr1),
    .waddr (caddr_wr[L1_AW-1:0]),
    .wdata (cdata_wr),
    .re    (rd1),
    .raddr (caddr_rd[L1_AW-1:0]),
    .rdata (rdata1)
  );

  always_comb begin
    rd_valid_d = rd_valid_q | rd0 | rd1;
    rd_bank_d  = rd_bank_q;
    if (rd0) rd_bank_d = 1'b0;
    if (rd1) rd_bank_d = 1'b1;
    cnt0_d = cnt0_q;
    if (wr0 && cnt0_q != CNT0_W'(L0_DEPTH)) cnt0_d = cnt0_q + 1'b1;
    cnt1_d = cnt1_q;
    if (wr1 && cnt1_q != CNT1_W'(L1_DEPTH)) cnt1_d = cnt1_q + 1'b1;
    err_d = err_q | wr_bad | rd_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      err_q      <= err_d;
    end
  end

  // RAM output registers are not reset; rd_valid_q masks them to zero until
  // the first legal read after reset, which gives the async-reset behaviour.
  assign cdata_rd = !rd_valid_q ? '0 : (rd_bank_q ? rdata1 : rdata0);
  assign wr_cnt0  = cnt0_q;
  assign wr_cnt1  = cnt1_q;
  assign l0_full  = (cnt0_q == CNT0_W'(L0_DEPTH));
  assign l1_full  = (cnt1_q == CNT1_W'(L1_DEPTH));
  assign sel_err  = err_q;

endmodule

// File: tb/tb_conv_layer_mem.sv
// Directed self-checking bench for conv_layer_mem: a vector table for single-cycle
// behaviour plus hand sequences for async reset, retention and counter saturation.
module tb_conv_layer_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  csel;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [12:0] wr_cnt0;
  logic [10:0] wr_cnt1;
  logic        l0_full;
  logic        l1_full;
  logic        sel_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_layer_mem dut (
    .clk      (clk),
    .reset    (reset),
    .csel     (csel),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .wr_cnt0  (wr_cnt0),
    .wr_cnt1  (wr_cnt1),
    .l0_full  (l0_full),
    .l1_full  (l1_full),
    .sel_err  (sel_err)
  );

  typedef struct {
    string       name;
    logic        cwr;
    logic        crd;
    logic [2:0]  csel;
    logic [11:0] waddr;
    logic [19:0] wdata;
    logic [11:0] raddr;
    logic [19:0] exp_rd;
    logic [12:0] exp_cnt0;
    logic [10:0] exp_cnt1;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    cwr = 1'b0; crd = 1'b0; csel = 3'b000;
    caddr_wr = '0; cdata_wr = '0; caddr_rd = '0;
  endtask

  // Drive one cycle of strobes, clock it, return 1 ns after the edge.
  task automatic cycle(input logic w, input logic r, input logic [2:0] s,
                       input logic [11:0] wa, input logic [19:0] wd, input logic [11:0] ra);
    cwr = w; crd = r; csel = s; caddr_wr = wa; cdata_wr = wd; caddr_rd = ra;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    //        name          cwr  crd  csel    waddr    wdata      raddr    rd         cnt0 cnt1 err
    vecs[0]  = '{"wr_l0_5",    1, 0, 3'b001, 12'h005, 20'h12345, 12'h000, 20'h00000, 1, 0, 0};
    vecs[1]  = '{"rd_l0_5",    0, 1, 3'b001, 12'h000, 20'h00000, 12'h005, 20'h12345, 1, 0, 0};
    vecs[2]  = '{"hold_idle",  0, 0, 3'b000, 12'h000, 20'h00000, 12'h000, 20'h12345, 1, 0, 0};
    vecs[3]  = '{"coll_l1",    1, 1, 3'b011, 12'h3FF, 20'hABCDE, 12'h3FF, 20'hABCDE, 1, 1, 0};
    vecs[4]  = '{"wr_l1_0",    1, 0, 3'b011, 12'h000, 20'h11111, 12'h000, 20'hABCDE, 1, 2, 0};
    vecs[5]  = '{"rw_diff",    1, 1, 3'b001, 12'h006, 20'h22222, 12'h005, 20'h12345, 2, 2, 0};
    vecs[6]  = '{"rd_l0_6",    0, 1, 3'b001, 12'h000, 20'h00000, 12'h006, 20'h22222, 2, 2, 0};
    vecs[7]  = '{"bad_csel",   1, 0, 3'b010, 12'h005, 20'h33333, 12'h000, 20'h22222, 2, 2, 1};
    vecs[8]  = '{"bad_l1_adr", 1, 0, 3'b011, 12'h400, 20'h44444, 12'h000, 20'h22222, 2, 2, 1};
    vecs[9]  = '{"rd_l1_0",    0, 1, 3'b011, 12'h000, 20'h00000, 12'h000, 20'h11111, 2, 2, 1};
    vecs[10] = '{"bad_rd_sel", 0, 1, 3'b000, 12'h000, 20'h00000, 12'h005, 20'h11111, 2, 2, 1};
    vecs[11] = '{"bad_rd_adr", 0, 1, 3'b011, 12'h000, 20'h00000, 12'h400, 20'h11111, 2, 2, 1};
    vecs[12] = '{"rd_l0_5b",   0, 1, 3'b001, 12'h000, 20'h00000, 12'h005, 20'h12345, 2, 2, 1};

    idle();
    reset = 1'b1;
    #3;
    chk("rst0_cdata_rd", 32'(cdata_rd), 32'h0);
    chk("rst0_wr_cnt0",  32'(wr_cnt0),  32'h0);
    chk("rst0_wr_cnt1",  32'(wr_cnt1),  32'h0);
    chk("rst0_l0_full",  32'(l0_full),  32'h0);
    chk("rst0_l1_full",  32'(l1_full),  32'h0);
    chk("rst0_sel_err",  32'(sel_err),  32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].cwr, vecs[i].crd, vecs[i].csel, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr);
      chk({vecs[i].name, "_cdata_rd"}, 32'(cdata_rd), 32'(vecs[i].exp_rd));
      chk({vecs[i].name, "_wr_cnt0"},  32'(wr_cnt0),  32'(vecs[i].exp_cnt0));
      chk({vecs[i].name, "_wr_cnt1"},  32'(wr_cnt1),  32'(vecs[i].exp_cnt1));
      chk({vecs[i].name, "_sel_err"},  32'(sel_err),  32'(vecs[i].exp_err));
      $display("vec %0d %s: rd=0x%05h cnt0=%0d cnt1=%0d err=%0b",
               i, vecs[i].name, cdata_rd, wr_cnt0, wr_cnt1, sel_err);
    end

    // Asynchronous reset in the middle of a cycle, checked before the next edge.
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_cdata_rd", 32'(cdata_rd), 32'h0);
    chk("mid_rst_wr_cnt0",  32'(wr_cnt0),  32'h0);
    chk("mid_rst_wr_cnt1",  32'(wr_cnt1),  32'h0);
    chk("mid_rst_sel_err",  32'(sel_err),  32'h0);
    $display("mid-cycle reset: rd=0x%05h cnt0=%0d cnt1=%0d err=%0b", cdata_rd, wr_cnt0, wr_cnt1, sel_err);
    @(posedge clk); #1;
    reset = 1'b0;

    // Contents survive reset.
    cycle(1'b0, 1'b1, 3'b001, 12'h000, 20'h0, 12'h005);
    chk("retain_l0_5",  32'(cdata_rd), 32'h12345);
    chk("retain_cnt0",  32'(wr_cnt0),  32'h0);
    cycle(1'b0, 1'b1, 3'b011, 12'h000, 20'h0, 12'h3FF);
    chk("retain_l1_3ff", 32'(cdata_rd), 32'hABCDE);
    $display("retention: L1[0x3ff]=0x%05h cnt0=%0d", cdata_rd, wr_cnt0);

    // Fill L0 and check saturation.
    for (int i = 0; i < 4096; i++) begin
      cycle(1'b1, 1'b0, 3'b001, 12'(i), 20'(i * 3 + 7), 12'h000);
      if (i == 4094) chk("l0_not_full_4095", 32'(l0_full), 32'h0);
    end
    chk("l0_full_4096", 32'(l0_full), 32'h1);
    chk("cnt0_4096",    32'(wr_cnt0), 32'd4096);
    cycle(1'b1, 1'b0, 3'b001, 12'h000, 20'hFFFFF, 12'h000);
    chk("cnt0_sat",     32'(wr_cnt0), 32'd4096);
    chk("l0_full_sat",  32'(l0_full), 32'h1);
    cycle(1'b0, 1'b1, 3'b001, 12'h000, 20'h0, 12'h000);
    chk("wr_at_sat_l0_0", 32'(cdata_rd), 32'hFFFFF);
    cycle(1'b0, 1'b1, 3'b001, 12'h000, 20'h0, 12'd100);
    chk("fill_l0_100", 32'(cdata_rd), 32'(100 * 3 + 7));
    $display("L0 fill: cnt0=%0d full=%0b L0[100]=0x%05h", wr_cnt0, l0_full, cdata_rd);

    // Fill L1 and check saturation.
    for (int i = 0; i < 1024; i++) begin
      cycle(1'b1, 1'b0, 3'b011, 12'(i), 20'(i + 20'h50000), 12'h000);
      if (i == 1022) chk("l1_not_full_1023", 32'(l1_full), 32'h0);
    end
    chk("l1_full_1024", 32'(l1_full), 32'h1);
    chk("cnt1_1024",    32'(wr_cnt1), 32'd1024);
    cycle(1'b1, 1'b0, 3'b011, 12'h001, 20'h0ABCD, 12'h000);
    chk("cnt1_sat",     32'(wr_cnt1), 32'd1024);
    cycle(1'b0, 1'b1, 3'b011, 12'h000, 20'h0, 12'h200);
    chk("fill_l1_200",  32'(cdata_rd), 32'h50200);
    chk("final_sel_err", 32'(sel_err), 32'h0);
    $display("L1 fill: cnt1=%0d full=%0b L1[0x200]=0x%05h", wr_cnt1, l1_full, cdata_rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
